fft16_stage_seq: RTL

//  Sequencer for the 16-point FFT first-stage butterfly datapath (FFT16).

---
 rtl/fft16_stage_seq_if.sv | 27 ++
 rtl/fft16_stage_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fft16_stage_seq_if.sv
// Stream interface for the FFT16 stage sequencer: sample input stream and
// indexed result output stream, each with a valid/ready handshake.
interface fft16_stage_seq_if #(
  parameter int DW = 16,
  parameter int OW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [3:0]    out_idx;
  logic          out_last;

  // Producer of samples / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/fft16_stage_seq.sv
// Sequencer around the 16-point first-stage butterfly datapath.
// Collects 16 samples into an input buffer, presents them on stg_in, waits out
// the datapath latency, captures the 16 results and streams them out by index.
// The input and result buffers are separate so the next frame can load while
// the current one drains.
module fft16_stage_seq #(
  parameter int N         = 16,
  parameter int DW        = 16,
  parameter int OW        = 64,
  parameter int STAGE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fft16_stage_seq_if.slave     bus,
  output logic [N*DW-1:0]      stg_in,
  input  logic [N*OW-1:0]      stg_out,
  output logic                 frame_done,
  output logic [7:0]           frame_cnt
);

  localparam int             CW       = (STAGE_LAT < 1) ? 1 : $clog2(STAGE_LAT + 1);
  localparam logic [CW-1:0]  CNT_INIT = CW'(STAGE_LAT);
  localparam logic [3:0]     LAST_IDX = 4'(N - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_DRAIN} state_e;

  // Input side
  logic          rdy_q, rdy_d;
  logic [3:0]    wr_idx_q, wr_idx_d;
  logic          full_q, full_d;
  logic [DW-1:0] smp_q [N];
  logic [DW-1:0] smp_d [N];
  logic          accept, full_set, capture;

  // Result side
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    rd_idx_q, rd_idx_d;
  logic [OW-1:0] res_q [N];
  logic [OW-1:0] res_d [N];
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  // Sample acceptance and input buffer fill; buffer is frozen while full.
  always_comb begin
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    accept   = bus.in_valid && bus.in_ready;
    full_set = accept && (wr_idx_q == LAST_IDX);
    capture  = (state_q == ST_WAIT) && (cnt_q == '0);
    rdy_d    = 1'b1;
    wr_idx_d = accept ? wr_idx_q + 4'd1 : wr_idx_q;
    full_d   = full_q;
    if (full_set) full_d = 1'b1;
    if (capture)  full_d = 1'b0;
    smp_d = smp_q;
    if (accept) smp_d[wr_idx_q] = bus.in_data;
  end

  // Input-side state registers; in_ready stays low until the first clock after reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      rdy_q    <= 1'b0;
      wr_idx_q <= '0;
      full_q   <= 1'b0;
      // NOTE: the buffers are reset because stg_in and out_data must read zero in reset.
      for (int k = 0; k < N; k++) smp_q[k] <= '0;
    end else begin
      rdy_q    <= rdy_d;
      wr_idx_q <= wr_idx_d;
      full_q   <= full_d;
      smp_q    <= smp_d;
    end
  end

  // Frame sequencing: LOAD -> WAIT (datapath latency) -> DRAIN (one result per handshake).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_idx_d     = rd_idx_q;
    res_d        = res_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        if (full_d) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          for (int k = 0; k < N; k++) res_d[k] = stg_out[k*OW +: OW];
          rd_idx_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          rd_idx_d = rd_idx_q + 4'd1;
          if (rd_idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            // A frame completing on this same edge goes straight to WAIT.
            if (full_d) begin
              state_d = ST_WAIT;
              cnt_d   = CNT_INIT;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Result-side state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      for (int k = 0; k < N; k++) res_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_idx_q     <= rd_idx_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      res_q        <= res_d;
    end
  end

  // Flatten the input buffer onto the datapath bus.
  always_comb begin
    stg_in = '0;
    for (int k = 0; k < N; k++) stg_in[k*DW +: DW] = smp_q[k];
  end

  assign bus.in_ready  = rdy_q && !full_q;
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.out_data  = res_q[rd_idx_q];
  assign bus.out_idx   = rd_idx_q;
  assign bus.out_last  = (state_q == ST_DRAIN) && (rd_idx_q == LAST_IDX);
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
